// File: rtl/burst_err_channel_pkg.sv
// Shared types and helpers for the burst error channel model.
// Optional statistics are enabled by defining BURST_ERR_STATS_EN.
package burst_err_channel_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } chan_state_t;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : (x + 16'd1);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] x, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, x} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  function automatic logic [31:0] popcount8(input logic [7:0] x);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {31'd0, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/burst_err_channel_if.sv
// Symbol bus between the encoder side, the channel model and the decoder side.
// Port names keep the channel's i/o naming so the bench reads like the block's pinout.
interface burst_err_channel_if #(
  parameter int W = 2
);
  logic          enable_i;
  logic          valid_i;
  logic [W-1:0]  d_i;
  logic [W-1:0]  err_mask_i;
  logic [7:0]    burst_len_i;
  logic          valid_o;
  logic [W-1:0]  d_o;
  logic          err_flag_o;
  logic [15:0]   burst_ct_o;
  logic [31:0]   sym_ct_o;
  logic [31:0]   bit_err_ct_o;

  modport master (
    output enable_i, valid_i, d_i, err_mask_i, burst_len_i,
    input  valid_o, d_o, err_flag_o, burst_ct_o, sym_ct_o, bit_err_ct_o
  );

  modport slave (
    input  enable_i, valid_i, d_i, err_mask_i, burst_len_i,
    output valid_o, d_o, err_flag_o, burst_ct_o, sym_ct_o, bit_err_ct_o
  );
endinterface

// File: rtl/burst_err_channel_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per accepted symbol.
// A zero seed would lock the register, so it is replaced by the default seed.
module chan_lfsr
  import burst_err_channel_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] state
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  // Shift register: reload seed on reset, shift left with feedback on each symbol
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else if (adv) begin
      state <= {state[14:0], fb};
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/burst_err_channel.sv
// Noisy channel model: one register stage, XORs err_mask_i onto symbols inside
// LFSR-triggered error bursts, each burst followed by a forced clean gap.
// Define BURST_ERR_STATS_EN to count flipped bits on bit_err_ct_o; otherwise it reads 0.
module burst_err_channel
  import burst_err_channel_pkg::*;
#(
  parameter int          W       = 2,
  parameter int          N       = 5,
  parameter int          GAP_LEN = 2,
  parameter int unsigned WINDOW  = 256,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input logic               clk,
  input logic               rst,
  burst_err_channel_if.slave bus
);

  // Trigger fires when the low N LFSR bits are all ones; N=0 gives an empty mask (always true)
  localparam logic [31:0] TRIG_M32  = (32'd1 << N) - 32'd1;
  localparam logic [15:0] TRIG_MASK = TRIG_M32[15:0];
  localparam logic [7:0]  GAP_INIT  = GAP_LEN[7:0];
  localparam logic [31:0] WIN       = WINDOW;

  chan_state_t  state, state_nxt;
  logic [7:0]   rem, rem_nxt;
  logic [7:0]   gap_ct, gap_nxt;
  logic [7:0]   len;
  logic [15:0]  lfsr;
  logic         trig, in_win, err, start;

  logic         valid_q;
  logic [W-1:0] d_q;
  logic         err_q;
  logic [15:0]  burst_ct;
  logic [31:0]  sym_ct;

  chan_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (bus.valid_i),
    .state (lfsr)
  );

  assign trig   = ((lfsr & TRIG_MASK) == TRIG_MASK);
  // Window test uses the count before this symbol is added
  assign in_win = (WIN == 32'd0) || (sym_ct < WIN);
  assign len    = (bus.burst_len_i == 8'd0) ? 8'd1 : bus.burst_len_i;

  // Burst FSM next state: decides whether the current symbol is errored
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    gap_nxt   = gap_ct;
    err       = 1'b0;
    start     = 1'b0;
    if (bus.valid_i) begin
      case (state)
        ST_CLEAN: begin
          if (bus.enable_i && in_win && trig) begin
            err   = 1'b1;
            start = 1'b1;
            if (len > 8'd1) begin
              state_nxt = ST_BURST;
              rem_nxt   = len - 8'd1;
            end else if (GAP_INIT != 8'd0) begin
              state_nxt = ST_GAP;
              gap_nxt   = GAP_INIT;
            end else begin
              state_nxt = ST_CLEAN;
            end
          end else begin
            state_nxt = ST_CLEAN;
          end
        end
        ST_BURST: begin
          if (!bus.enable_i || !in_win) begin
            // Truncated burst: this symbol is clean and no gap is owed
            state_nxt = ST_CLEAN;
            rem_nxt   = 8'd0;
          end else begin
            err     = 1'b1;
            rem_nxt = rem - 8'd1;
            if (rem > 8'd1) begin
              state_nxt = ST_BURST;
            end else if (GAP_INIT != 8'd0) begin
              state_nxt = ST_GAP;
              gap_nxt   = GAP_INIT;
            end else begin
              state_nxt = ST_CLEAN;
            end
          end
        end
        ST_GAP: begin
          gap_nxt = gap_ct - 8'd1;
          if (gap_ct > 8'd1) begin
            state_nxt = ST_GAP;
          end else begin
            state_nxt = ST_CLEAN;
          end
        end
        default: begin
          state_nxt = ST_CLEAN;
          rem_nxt   = 8'd0;
          gap_nxt   = 8'd0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Burst FSM state and remaining-length / gap counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_CLEAN;
      rem    <= 8'd0;
      gap_ct <= 8'd0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      gap_ct <= gap_nxt;
    end
  end

  // Output stage: register the (possibly corrupted) symbol, hold it while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      d_q     <= {W{1'b0}};
      err_q   <= 1'b0;
    end else if (bus.valid_i) begin
      valid_q <= 1'b1;
      d_q     <= bus.d_i ^ (err ? bus.err_mask_i : {W{1'b0}});
      err_q   <= err;
    end else begin
      valid_q <= 1'b0;
      d_q     <= d_q;
      err_q   <= err_q;
    end
  end

  // Saturating symbol and burst-start counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_ct   <= 32'd0;
      burst_ct <= 16'd0;
    end else begin
      sym_ct   <= bus.valid_i ? sat_add32(sym_ct, 32'd1) : sym_ct;
      burst_ct <= start ? sat_inc16(burst_ct) : burst_ct;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.d_o        = d_q;
  assign bus.err_flag_o = err_q;
  assign bus.burst_ct_o = burst_ct;
  assign bus.sym_ct_o   = sym_ct;

`ifdef BURST_ERR_STATS_EN
  logic [31:0] bit_err_ct;

  // Accumulate the number of bits actually flipped on errored symbols
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_err_ct <= 32'd0;
    end else if (err) begin
      bit_err_ct <= sat_add32(bit_err_ct, popcount8(8'(bus.err_mask_i)));
    end else begin
      bit_err_ct <= bit_err_ct;
    end
  end

  assign bus.bit_err_ct_o = bit_err_ct;
`else
  assign bus.bit_err_ct_o = 32'd0;
`endif

endmodule

// File: tb/tb_burst_err_channel.sv
// Directed bench for burst_err_channel with a behavioural model feeding a scoreboard.
// Three instances: dut0 (N=0, no window), dut1 (N=0, WINDOW=8), dut2 (N=5, zero seed).
// Honours BURST_ERR_STATS_EN when computing expected bit_err_ct_o.
module tb_burst_err_channel;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  burst_err_channel_if #(.W(2)) bus0 ();
  burst_err_channel_if #(.W(2)) bus1 ();
  burst_err_channel_if #(.W(2)) bus2 ();

  burst_err_channel #(.W(2), .N(0), .GAP_LEN(GAP), .WINDOW(0), .SEED(16'hACE1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  burst_err_channel #(.W(2), .N(0), .GAP_LEN(GAP), .WINDOW(8), .SEED(16'hACE1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  burst_err_channel #(.W(2), .N(5), .GAP_LEN(GAP), .WINDOW(0), .SEED(16'h0000))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Model state per instance
  int          m_n   [3] = '{0, 0, 5};
  int unsigned m_win [3] = '{0, 8, 0};
  logic [15:0] m_lfsr[3];
  int          m_st  [3];
  int          m_rem [3];
  int          m_gap [3];
  int unsigned m_sym [3];
  int          m_burst[3];
  int          m_bits[3];
  logic [1:0]  m_last_d[3];
  logic        m_last_err[3];

  typedef struct packed {
    logic [1:0] d;
    logic       err;
  } exp_t;

  exp_t sb [3][$];
  logic log0[$];
  logic log1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic [1:0] d,
                       input logic [1:0] mask, input logic [7:0] bl);
    bus0.valid_i = v; bus0.enable_i = en; bus0.d_i = d; bus0.err_mask_i = mask; bus0.burst_len_i = bl;
    bus1.valid_i = v; bus1.enable_i = en; bus1.d_i = d; bus1.err_mask_i = mask; bus1.burst_len_i = bl;
    bus2.valid_i = v; bus2.enable_i = en; bus2.d_i = d; bus2.err_mask_i = mask; bus2.burst_len_i = bl;
  endtask

  task automatic read_bus(input int k, output logic v, output logic [1:0] d, output logic e,
                          output logic [15:0] bc, output logic [31:0] sc, output logic [31:0] be);
    case (k)
      0: begin v = bus0.valid_o; d = bus0.d_o; e = bus0.err_flag_o;
               bc = bus0.burst_ct_o; sc = bus0.sym_ct_o; be = bus0.bit_err_ct_o; end
      1: begin v = bus1.valid_o; d = bus1.d_o; e = bus1.err_flag_o;
               bc = bus1.burst_ct_o; sc = bus1.sym_ct_o; be = bus1.bit_err_ct_o; end
      default: begin v = bus2.valid_o; d = bus2.d_o; e = bus2.err_flag_o;
               bc = bus2.burst_ct_o; sc = bus2.sym_ct_o; be = bus2.bit_err_ct_o; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lfsr[k] = 16'hACE1;
      m_st[k] = 0; m_rem[k] = 0; m_gap[k] = 0;
      m_sym[k] = 0; m_burst[k] = 0; m_bits[k] = 0;
      m_last_d[k] = 2'b00; m_last_err[k] = 1'b0;
      sb[k].delete();
    end
  endtask

  // One accepted symbol through the reference model of instance k
  task automatic model_sym(input int k, input logic en, input logic [1:0] d,
                           input logic [1:0] mask, input logic [7:0] bl);
    logic trig, inw, err, fb;
    int   len;
    trig = 1'b1;
    for (int b = 0; b < m_n[k]; b++) if (!m_lfsr[k][b]) trig = 1'b0;
    inw = (m_win[k] == 0) || (m_sym[k] < m_win[k]);
    len = (bl == 8'd0) ? 1 : int'(bl);
    err = 1'b0;
    case (m_st[k])
      0: if (en && inw && trig) begin
           err = 1'b1;
           m_burst[k]++;
           if (len > 1) begin m_st[k] = 1; m_rem[k] = len - 1; end
           else begin m_st[k] = 2; m_gap[k] = GAP; end
         end
      1: if (!en || !inw) m_st[k] = 0;
         else begin
           err = 1'b1;
           m_rem[k]--;
           if (m_rem[k] == 0) begin m_st[k] = 2; m_gap[k] = GAP; end
         end
      2: begin m_gap[k]--; if (m_gap[k] == 0) m_st[k] = 0; end
      default: m_st[k] = 0;
    endcase
    if (err) m_bits[k] += int'(mask[0]) + int'(mask[1]);
    m_sym[k]++;
    fb = m_lfsr[k][15] ^ m_lfsr[k][13] ^ m_lfsr[k][12] ^ m_lfsr[k][10];
    m_lfsr[k] = {m_lfsr[k][14:0], fb};
    sb[k].push_back({(err ? (d ^ mask) : d), err});
  endtask

  task automatic send(input logic v, input logic en, input logic [1:0] d,
                      input logic [1:0] mask, input logic [7:0] bl);
    logic v_o, e_o;
    logic [1:0] d_o;
    logic [15:0] bc;
    logic [31:0] sc, be;
    exp_t x;
    @(negedge clk);
    drive(v, en, d, mask, bl);
    if (v) for (int k = 0; k < 3; k++) model_sym(k, en, d, mask, bl);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      read_bus(k, v_o, d_o, e_o, bc, sc, be);
      check($sformatf("valid_o[%0d]", k), 32'(v_o), 32'(v));
      if (v && sb[k].size() > 0) begin
        x = sb[k].pop_front();
        m_last_d[k] = x.d;
        m_last_err[k] = x.err;
      end
      check($sformatf("d_o[%0d]", k), 32'(d_o), 32'(m_last_d[k]));
      check($sformatf("err_flag_o[%0d]", k), 32'(e_o), 32'(m_last_err[k]));
      if (v && k == 0) log0.push_back(e_o);
      if (v && k == 1) log1.push_back(e_o);
    end
  endtask

  task automatic check_counters(input string tag);
    logic v_o, e_o;
    logic [1:0] d_o;
    logic [15:0] bc;
    logic [31:0] sc, be, exp_be;
    for (int k = 0; k < 3; k++) begin
      read_bus(k, v_o, d_o, e_o, bc, sc, be);
`ifdef BURST_ERR_STATS_EN
      exp_be = 32'(m_bits[k]);
`else
      exp_be = 32'd0;
`endif
      check($sformatf("%s_burst_ct[%0d]", tag, k), 32'(bc), 32'(m_burst[k]));
      check($sformatf("%s_sym_ct[%0d]", tag, k), sc, 32'(m_sym[k]));
      check($sformatf("%s_bit_err_ct[%0d]", tag, k), be, exp_be);
    end
  endtask

  task automatic check_pattern(input string tag, input string pat, input logic lg[$]);
    check({tag, "_len"}, 32'(lg.size()), 32'(pat.len()));
    for (int i = 0; i < pat.len() && i < lg.size(); i++) begin
      check($sformatf("%s_sym%0d", tag, i), 32'(lg[i]), 32'(pat[i] == "E"));
    end
  endtask

  // Reset asserted for one edge with live traffic on the inputs; all outputs must clear
  task automatic do_reset();
    logic v_o, e_o;
    logic [1:0] d_o;
    logic [15:0] bc;
    logic [31:0] sc, be;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 2'b11, 8'd5);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      read_bus(k, v_o, d_o, e_o, bc, sc, be);
      check($sformatf("rst_valid_o[%0d]", k), 32'(v_o), 32'd0);
      check($sformatf("rst_d_o[%0d]", k), 32'(d_o), 32'd0);
      check($sformatf("rst_err_flag_o[%0d]", k), 32'(e_o), 32'd0);
      check($sformatf("rst_burst_ct[%0d]", k), 32'(bc), 32'd0);
      check($sformatf("rst_sym_ct[%0d]", k), sc, 32'd0);
      check($sformatf("rst_bit_err_ct[%0d]", k), be, 32'd0);
    end
    model_reset();
    log0.delete();
    log1.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
  endtask

  initial begin
    logic v_o, e_o;
    logic [1:0] d_o;
    logic [15:0] bc;
    logic [31:0] sc, be;

    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'd0);
    model_reset();
    do_reset();

    // Transparent channel
    for (int i = 0; i < 100; i++) send(1'b1, 1'b0, 2'b01, 2'b11, 8'd3);
    check_counters("s1");
    read_bus(0, v_o, d_o, e_o, bc, sc, be);
    check("s1_burst_ct_zero", 32'(bc), 32'd0);
    check("s1_sym_ct_100", sc, 32'd100);

    // Back-to-back bursts of 3 with gap 2; dut1 stops injecting at symbol 8
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b1, 1'b1, 2'($urandom), 2'b11, 8'd3);
    check_counters("s2");
    read_bus(0, v_o, d_o, e_o, bc, sc, be);
    check("s2_burst_ct_2", 32'(bc), 32'd2);
`ifdef BURST_ERR_STATS_EN
    check("s2_bit_err_12", be, 32'd12);
`else
    check("s2_bit_err_0", be, 32'd0);
`endif
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, 2'($urandom), 2'b11, 8'd3);
    check_pattern("s2_pat", "EEECCEEECCEEECCE", log0);
    check_pattern("s3_win", "EEECCEEECCCCCCCC", log1);
    check_counters("s3");

    // Same traffic with idle cycles between symbols
    do_reset();
    for (int i = 0; i < 20; i++) send((i % 2) == 0, 1'b1, 2'($urandom), 2'b11, 8'd3);
    check_pattern("s4_pat", "EEECCEEECC", log0);
    check_counters("s4");

    // Burst length changes, zero length, and enable drop mid-burst
    do_reset();
    send(1'b1, 1'b1, 2'($urandom), 2'b01, 8'd3);
    for (int i = 1; i < 12; i++) send(1'b1, 1'b1, 2'($urandom), 2'b10, 8'd5);
    for (int i = 12; i < 21; i++) send(1'b1, 1'b1, 2'($urandom), 2'b11, 8'd0);
    send(1'b1, 1'b1, 2'($urandom), 2'b11, 8'd4);
    send(1'b1, 1'b0, 2'($urandom), 2'b11, 8'd4);
    for (int i = 23; i < 29; i++) send(1'b1, 1'b1, 2'($urandom), 2'b01, 8'd4);
    check_pattern("s5_pat", "EEECCEEEEECCECCECCECCECEEEECC", log0);
    read_bus(0, v_o, d_o, e_o, bc, sc, be);
    check("s5_burst_ct_7", 32'(bc), 32'd7);
    check_counters("s5");

    // Reset in the middle of a burst, then two identical pseudo-random runs
    do_reset();
    send(1'b1, 1'b1, 2'b00, 2'b11, 8'd5);
    send(1'b1, 1'b1, 2'b00, 2'b11, 8'd5);
    do_reset();
    for (int i = 0; i < 300; i++) send(1'b1, 1'b1, 2'($urandom), 2'($urandom), 8'd4);
    check_counters("s6a");
    do_reset();
    for (int i = 0; i < 300; i++) send(1'b1, 1'b1, 2'($urandom), 2'($urandom), 8'd4);
    check_counters("s6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
